// File: rtl/pc_pkg.sv
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared encodings for the program-counter sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // ACT_HOLD covers a disabled or halted cycle; the rest follow command priority.
    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_INC  = 3'd1,
        ACT_BR   = 3'd2,
        ACT_JMP  = 3'd3,
        ACT_CALL = 3'd4,
        ACT_RET  = 3'd5
    } act_t;

endpackage

`default_nettype wire

// File: rtl/pc_ret_stack.sv
// ============================================================================
// Module   : pc_ret_stack
// Purpose  : Circular return-address stack with count and ovf/unf flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_data = mem[ptr_q];
    assign ovf      = ovf_q;
    assign unf      = unf_q;

    // ptr_q always points at the newest entry; when full, ptr_q+1 is the oldest
    // so a push naturally overwrites it.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (full) ovf_d = 1'b1;
            else      count_d = count_q + CNT_W'(1);
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= PTR_W'(DEPTH - 1);
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[ptr_d] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-stage PC with branch, jump, call/return and HALT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                OFF_W       = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_enable,
    input  logic              branch_taken,
    input  logic [OFF_W-1:0]  branch_offset,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_ovf,
    output logic              stack_unf
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    act_t              act;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] off_sext;
    logic [ADDR_W-1:0] pop_data;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign off_sext = {{(ADDR_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
    assign pc_out   = pc_q;
    assign halted   = halted_q;

    always_comb begin
        act = ACT_HOLD;
        if (state_q == ST_RUN && pc_enable) begin
            if      (ret)          act = ACT_RET;
            else if (call)         act = ACT_CALL;
            else if (jump)         act = ACT_JMP;
            else if (branch_taken) act = ACT_BR;
            else                   act = ACT_INC;
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (act)
            ACT_INC:  pc_d = pc_inc;
            ACT_BR:   pc_d = pc_q + off_sext;
            ACT_JMP:  pc_d = jump_target;
            ACT_CALL: pc_d = jump_target;
            ACT_RET:  pc_d = stack_empty ? RESET_VEC : pop_data;
            default:  pc_d = pc_q;
        endcase

        state_d = state_q;
        case (state_q)
            ST_RUN:  if (pc_enable && halt) state_d = ST_HALT;
            ST_HALT: if (resume)            state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_VEC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    pc_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (act == ACT_CALL),
        .pop       (act == ACT_RET),
        .push_data (pc_inc),
        .pop_data  (pop_data),
        .empty     (stack_empty),
        .full      (stack_full),
        .ovf       (stack_ovf),
        .unf       (stack_unf)
    );

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_enable, branch_taken, jump, call, ret, halt, resume;
    logic [7:0]  branch_offset;
    logic [15:0] jump_target;
    logic [15:0] pc_out;
    logic        halted, stack_empty, stack_full, stack_ovf, stack_unf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W      (16),
        .OFF_W       (8),
        .STACK_DEPTH (4),
        .RESET_VEC   (16'h0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_enable     (pc_enable),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_target   (jump_target),
        .halt          (halt),
        .resume        (resume),
        .pc_out        (pc_out),
        .halted        (halted),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .stack_ovf     (stack_ovf),
        .stack_unf     (stack_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch_taken = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
        halt = 1'b0; resume = 1'b0;
    endtask

    task automatic do_jump(input logic [15:0] tgt);
        idle();
        jump = 1'b1; jump_target = tgt;
        step();
        jump = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pc_enable = 1'b0; branch_offset = 8'h00; jump_target = 16'h0000;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc_out), 32'h0000);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_empty", 32'(stack_empty), 32'h1);
        check("rst_full", 32'(stack_full), 32'h0);
        check("rst_ovf", 32'(stack_ovf), 32'h0);
        check("rst_unf", 32'(stack_unf), 32'h0);

        reset = 1'b0; pc_enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("count", 32'(pc_out), 32'(i));
        end
        #2 reset = 1'b1;
        #1 check("async_rst_pc", 32'(pc_out), 32'h0000);
        reset = 1'b0;

        do_jump(16'hFFFF);
        check("jump_ffff", 32'(pc_out), 32'hFFFF);
        step();
        check("wrap", 32'(pc_out), 32'h0000);

        do_jump(16'h0010);
        branch_taken = 1'b1; branch_offset = 8'hF0;
        step();
        check("br_neg", 32'(pc_out), 32'h0000);
        idle();
        do_jump(16'h0010);
        branch_taken = 1'b1; branch_offset = 8'h05;
        step();
        check("br_pos", 32'(pc_out), 32'h0015);
        idle();

        do_jump(16'h0100);
        call = 1'b1; jump_target = 16'h0200;
        step();
        check("call_pc", 32'(pc_out), 32'h0200);
        check("call_nonempty", 32'(stack_empty), 32'h0);
        call = 1'b0; ret = 1'b1;
        step();
        check("ret_pc", 32'(pc_out), 32'h0101);
        check("ret_empty", 32'(stack_empty), 32'h1);
        ret = 1'b0;

        do_jump(16'h0010);
        for (int i = 1; i <= 5; i++) begin
            call = 1'b1; jump_target = 16'((i + 1) * 16);
            step();
            check("call_chain_pc", 32'(pc_out), 32'((i + 1) * 16));
            check("call_chain_ovf", 32'(stack_ovf), 32'(i == 5));
            if (i == 4) check("full_after4", 32'(stack_full), 32'h1);
        end
        call = 1'b0; ret = 1'b1;
        step();
        check("ovf_clear", 32'(stack_ovf), 32'h0);
        check("pop1", 32'(pc_out), 32'h0051);
        step(); check("pop2", 32'(pc_out), 32'h0041);
        step(); check("pop3", 32'(pc_out), 32'h0031);
        step(); check("pop4", 32'(pc_out), 32'h0021);
        check("empty_after_pops", 32'(stack_empty), 32'h1);
        step();
        check("unf_pc", 32'(pc_out), 32'h0000);
        check("unf_pulse", 32'(stack_unf), 32'h1);
        ret = 1'b0;
        step();
        check("unf_clear", 32'(stack_unf), 32'h0);
        check("after_unf_inc", 32'(pc_out), 32'h0001);

        do_jump(16'h0300);
        call = 1'b1; jump_target = 16'h0400;
        step();
        ret = 1'b1; call = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        jump_target = 16'h0500; branch_offset = 8'h07;
        step();
        check("prio_ret", 32'(pc_out), 32'h0301);
        check("prio_empty", 32'(stack_empty), 32'h1);
        idle();
        pc_enable = 1'b0; jump = 1'b1;
        step(); step();
        check("disable_hold", 32'(pc_out), 32'h0301);
        pc_enable = 1'b1;

        do_jump(16'h0007);
        halt = 1'b1;
        step();
        check("halt_pc", 32'(pc_out), 32'h0008);
        check("halt_flag", 32'(halted), 32'h1);
        halt = 1'b0; jump = 1'b1; jump_target = 16'h0500;
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_hold", 32'(pc_out), 32'h0008);
        end
        jump = 1'b0; resume = 1'b1;
        step();
        check("resume_flag", 32'(halted), 32'h0);
        check("resume_pc", 32'(pc_out), 32'h0008);
        resume = 1'b0;
        step();
        check("resume_count", 32'(pc_out), 32'h0009);

        do_jump(16'h0020);
        halt = 1'b1;
        step();
        check("halt2_flag", 32'(halted), 32'h1);
        halt = 1'b0;
        #2 reset = 1'b1;
        #1 check("async_rst_halt", 32'(halted), 32'h0);
        check("async_rst_pc2", 32'(pc_out), 32'h0000);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
